time_set_converter: RTL and testbench
=====================================

# time_set_converter

Time-entry block for the desk alarm clock. It captures the current 24 h time into a staging register kept in the user's display format (12 h or 24 h), and edits it with hour/minute increment strobes. On commit it converts the staged value back to 24 h format and hands it to the time/alarm counter over a valid/ready handshake. It sits between the button debouncers and the clock/alarm counters, opposite the display-side 24 h→12 h mode converter.

## Interface
Parameters:
- none; widths fixed by shared package constants

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_12h_mode  input  1  display mode; sampled only on accepted i_start
- i_cur_hours  input  5  current hours, 24 h format, 0–23
- i_cur_minutes  input  6  current minutes, 0–59
- i_start  input  1  single-cycle strobe: capture current time, enter edit
- i_inc_hours  input  1  single-cycle strobe: increment staged hours
- i_inc_minutes  input  1  single-cycle strobe: increment staged minutes
- i_commit  input  1  single-cycle strobe: convert and offer staged time
- i_cancel  input  1  single-cycle strobe: abandon edit
- i_set_ready  input  1  downstream counter accepts the offered time
- o_editing  output  1  high in EDIT
- o_disp_hours  output  5  staged hours in latched display format
- o_disp_minutes  output  6  staged minutes
- o_disp_pm  output  1  staged PM flag; 0 in 24 h mode
- o_set_valid  output  1  offered time valid
- o_hours  output  5  offered hours, 24 h format
- o_minutes  output  6  offered minutes
- o_seconds  output  6  offered seconds, always 0

## Operation
- States: IDLE, EDIT, COMMIT.
  - IDLE→EDIT on i_start.
  - EDIT→IDLE on i_cancel.
  - EDIT→COMMIT on i_commit.
  - COMMIT→IDLE when i_set_ready=1.
- i_start is ignored outside IDLE. All edit strobes are ignored outside EDIT.
- Capture on i_start:
  - Latch mode_12h from i_12h_mode; the mode is frozen until the next capture.
  - Staged minutes = i_cur_minutes.
  - 24 h mode: staged hours = i_cur_hours; pm=0.
  - 12 h mode: 0→12 AM; 1–11→h AM; 12→12 PM; 13–23→h−12 PM.
  - Out-of-range inputs (hours>23, minutes>59) are captured as 0 (12 AM in 12 h mode).
- Hour increment:
  - 24 h mode: 23→0, else +1.
  - 12 h mode: 11→12 and toggle pm; 12→1 with no toggle; else +1.
- Minute increment: 59→0, else +1. Never carries into hours.
- Same-cycle priority in EDIT: i_cancel > i_commit > increments. i_inc_hours and i_inc_minutes together: both apply.
- Commit conversion to 24 h:
  - 24 h mode: o_hours = staged hours.
  - 12 h mode: hours 12 → pm?12:0; otherwise hours + (pm?12:0).
  - o_minutes = staged minutes; o_seconds = 0.

## Timing
- Reset values:
  - state IDLE
  - o_editing 0, o_set_valid 0
  - o_hours, o_minutes, o_seconds 0
  - o_disp_hours, o_disp_minutes 0, o_disp_pm 0
  - mode_12h 0
- All outputs are registered. Reset is asynchronous and overrides everything, including mid-edit and mid-handshake; no partial commit survives.
- Capture: i_start at edge N gives o_editing=1 and staged values visible after edge N.
- Increments: each strobe takes effect at the edge where it is sampled, so a 1-cycle latency to o_disp_*. Back-to-back strobes on consecutive cycles each count.
- Commit:
  - i_commit at edge N: o_set_valid=1 and o_hours/o_minutes valid after edge N; o_editing=0 after edge N.
  - Offered values are stable while o_set_valid=1.
  - Transfer occurs at the edge where o_set_valid=1 and i_set_ready=1; o_set_valid drops after that edge.
  - Minimum offer length is 1 cycle, when i_set_ready is already high.
- o_disp_* hold their last staged value in IDLE and COMMIT.

## Structure
- Shared package holds:
  - width constants: HOURS_W=5, MINUTES_W=6, SECONDS_W=6
  - limits: HOURS_24_MAX=23, HOURS_12_MAX=12, MINUTES_MAX=59
  - state encoding: IDLE, EDIT, COMMIT
- One natural combinational sub-module, display_to_24h: inputs mode_12h, hours, pm; output 24 h hours. It is instantiated at commit so the verification engineer can unit-test it exhaustively.

## Test plan
- Reset mid-EDIT and mid-COMMIT (o_set_valid=1) → all outputs return to reset values immediately; state IDLE.
- 12 h capture of i_cur_hours 0, 12, 13, 23 → o_disp_hours/o_disp_pm = 12/0, 12/1, 1/1, 11/1.
- 12 h mode, staged 11 AM, two i_inc_hours → 12 PM then 1 PM. Commit → o_hours 12, then 13 on a second run.
- 24 h mode, staged 23:59, i_inc_hours and i_inc_minutes in the same cycle → 0:00. Commit → o_hours 0, o_minutes 0, o_seconds 0.
- Commit with i_set_ready low for 3 cycles → o_set_valid held with stable values for 4 cycles; drops after the accepting edge.
- In EDIT, i_cancel and i_commit in the same cycle → IDLE, o_set_valid stays 0. A toggle of i_12h_mode mid-edit leaves o_disp_* unchanged.

Source files
------------

// File: rtl/time_set_converter_pkg.sv
// Shared widths, limits, FSM encoding and time-arithmetic helpers for the
// alarm-clock time-entry block.
package time_set_converter_pkg;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;
    localparam int SECONDS_W = 6;

    typedef logic [HOURS_W-1:0]   hours_t;
    typedef logic [MINUTES_W-1:0] minutes_t;
    typedef logic [SECONDS_W-1:0] seconds_t;

    localparam hours_t   HOURS_24_MAX = 5'd23;
    localparam hours_t   HOURS_12_MAX = 5'd12;
    localparam minutes_t MINUTES_MAX  = 6'd59;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef struct packed {
        logic   pm;
        hours_t hours;
    } disp_hours_t;

    // Out-of-range hours are captured as midnight before any 12 h folding.
    function automatic disp_hours_t capture_hours(input hours_t h24, input logic mode_12h);
        disp_hours_t r;
        hours_t      h;
        h       = (h24 > HOURS_24_MAX) ? '0 : h24;
        r.pm    = 1'b0;
        r.hours = h;
        if (mode_12h) begin
            if (h == '0) begin
                r.hours = HOURS_12_MAX;
            end else if (h >= HOURS_12_MAX) begin
                r.pm = 1'b1;
                if (h != HOURS_12_MAX) begin
                    r.hours = h - HOURS_12_MAX;
                end
            end
        end
        return r;
    endfunction

    // In 12 h mode the AM/PM flip happens on 11->12, not on 12->1.
    function automatic disp_hours_t next_hours(input disp_hours_t cur, input logic mode_12h);
        disp_hours_t r;
        r = cur;
        if (!mode_12h) begin
            r.hours = (cur.hours == HOURS_24_MAX) ? '0 : cur.hours + hours_t'(1);
        end else if (cur.hours == HOURS_12_MAX) begin
            r.hours = hours_t'(1);
        end else begin
            if (cur.hours == HOURS_12_MAX - hours_t'(1)) begin
                r.pm = ~cur.pm;
            end
            r.hours = cur.hours + hours_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/time_set_converter_if.sv
// Button-side strobes, display view and valid/ready offer to the time counter.
interface time_set_converter_if;
    import time_set_converter_pkg::*;

    logic     i_12h_mode;
    hours_t   i_cur_hours;
    minutes_t i_cur_minutes;
    logic     i_start;
    logic     i_inc_hours;
    logic     i_inc_minutes;
    logic     i_commit;
    logic     i_cancel;
    logic     i_set_ready;
    logic     o_editing;
    hours_t   o_disp_hours;
    minutes_t o_disp_minutes;
    logic     o_disp_pm;
    logic     o_set_valid;
    hours_t   o_hours;
    minutes_t o_minutes;
    seconds_t o_seconds;

    modport master (
        output i_12h_mode, i_cur_hours, i_cur_minutes, i_start, i_inc_hours,
               i_inc_minutes, i_commit, i_cancel, i_set_ready,
        input  o_editing, o_disp_hours, o_disp_minutes, o_disp_pm, o_set_valid,
               o_hours, o_minutes, o_seconds
    );

    modport slave (
        input  i_12h_mode, i_cur_hours, i_cur_minutes, i_start, i_inc_hours,
               i_inc_minutes, i_commit, i_cancel, i_set_ready,
        output o_editing, o_disp_hours, o_disp_minutes, o_disp_pm, o_set_valid,
               o_hours, o_minutes, o_seconds
    );
endinterface

// File: rtl/time_set_converter_display_to_24h.sv
// Converts a staged display-format hour (12 h with PM flag, or plain 24 h)
// back to 24 h format.
module display_to_24h
    import time_set_converter_pkg::*;
(
    input  logic   mode_12h_i,
    input  hours_t hours_i,
    input  logic   pm_i,
    output hours_t hours_24_o
);

    // 12 AM is midnight (0) and 12 PM is noon (12); other PM hours shift by 12.
    always_comb begin
        hours_24_o = hours_i;
        if (mode_12h_i) begin
            if (hours_i == HOURS_12_MAX) begin
                hours_24_o = pm_i ? HOURS_12_MAX : '0;
            end else if (pm_i) begin
                hours_24_o = hours_i + HOURS_12_MAX;
            end
        end
    end

endmodule

// File: rtl/time_set_converter.sv
// Time-entry FSM: captures current time in display format, edits it with
// increment strobes and offers the 24 h result over valid/ready.
module time_set_converter
    import time_set_converter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    time_set_converter_if.slave  bus
);

    logic [1:0]  state_q, state_d;
    logic        mode_12h_q, mode_12h_d;
    disp_hours_t disp_q, disp_d;
    minutes_t    minutes_q, minutes_d;
    logic        editing_q, editing_d;
    logic        valid_q, valid_d;
    hours_t      out_hours_q, out_hours_d;
    minutes_t    out_minutes_q, out_minutes_d;
    hours_t      hours_24;

    display_to_24h u_display_to_24h (
        .mode_12h_i (mode_12h_q),
        .hours_i    (disp_q.hours),
        .pm_i       (disp_q.pm),
        .hours_24_o (hours_24)
    );

    // Within EDIT, cancel beats commit and commit beats the increments.
    always_comb begin
        state_d       = state_q;
        mode_12h_d    = mode_12h_q;
        disp_d        = disp_q;
        minutes_d     = minutes_q;
        out_hours_d   = out_hours_q;
        out_minutes_d = out_minutes_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d    = ST_EDIT;
                    mode_12h_d = bus.i_12h_mode;
                    disp_d     = capture_hours(bus.i_cur_hours, bus.i_12h_mode);
                    minutes_d  = (bus.i_cur_minutes > MINUTES_MAX) ? '0 : bus.i_cur_minutes;
                end
            end
            ST_EDIT: begin
                if (bus.i_cancel) begin
                    state_d = ST_IDLE;
                end else if (bus.i_commit) begin
                    state_d       = ST_COMMIT;
                    out_hours_d   = hours_24;
                    out_minutes_d = minutes_q;
                end else begin
                    if (bus.i_inc_hours) begin
                        disp_d = next_hours(disp_q, mode_12h_q);
                    end
                    if (bus.i_inc_minutes) begin
                        minutes_d = (minutes_q == MINUTES_MAX) ? '0 : minutes_q + minutes_t'(1);
                    end
                end
            end
            ST_COMMIT: begin
                if (bus.i_set_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        editing_d = (state_d == ST_EDIT);
        valid_d   = (state_d == ST_COMMIT);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            mode_12h_q    <= 1'b0;
            disp_q        <= '0;
            minutes_q     <= '0;
            editing_q     <= 1'b0;
            valid_q       <= 1'b0;
            out_hours_q   <= '0;
            out_minutes_q <= '0;
        end else begin
            state_q       <= state_d;
            mode_12h_q    <= mode_12h_d;
            disp_q        <= disp_d;
            minutes_q     <= minutes_d;
            editing_q     <= editing_d;
            valid_q       <= valid_d;
            out_hours_q   <= out_hours_d;
            out_minutes_q <= out_minutes_d;
        end
    end

    assign bus.o_editing      = editing_q;
    assign bus.o_disp_hours   = disp_q.hours;
    assign bus.o_disp_pm      = disp_q.pm;
    assign bus.o_disp_minutes = minutes_q;
    assign bus.o_set_valid    = valid_q;
    assign bus.o_hours        = out_hours_q;
    assign bus.o_minutes      = out_minutes_q;
    assign bus.o_seconds      = '0;

endmodule

// File: tb/tb_time_set_converter.sv
// Directed self-checking bench for time_set_converter with hand-computed
// expected values for capture, increment, commit and handshake behaviour.
module tb_time_set_converter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    time_set_converter_if tsc ();

    time_set_converter dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (tsc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doCapture(input logic mode, input logic [4:0] h, input logic [5:0] m);
        tsc.i_12h_mode    = mode;
        tsc.i_cur_hours   = h;
        tsc.i_cur_minutes = m;
        tsc.i_start       = 1'b1;
        tick();
        tsc.i_start       = 1'b0;
    endtask

    task automatic doCancel();
        tsc.i_cancel = 1'b1;
        tick();
        tsc.i_cancel = 1'b0;
    endtask

    task automatic doIncHours();
        tsc.i_inc_hours = 1'b1;
        tick();
        tsc.i_inc_hours = 1'b0;
    endtask

    task automatic doCommit();
        tsc.i_commit = 1'b1;
        tick();
        tsc.i_commit = 1'b0;
    endtask

    // Packs every output as {editing, valid, hours, minutes, seconds, dispH, dispM, pm}.
    function automatic logic [35:0] allOutputs();
        return {tsc.o_editing, tsc.o_set_valid, tsc.o_hours, tsc.o_minutes, tsc.o_seconds,
                tsc.o_disp_hours, tsc.o_disp_minutes, tsc.o_disp_pm};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (allOutputs() !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_values got %h want %h", allOutputs(), 36'h0);
        end
        #2 reset = 1'b0;
        tick();
        checks++;
        if (allOutputs() !== 36'h0) begin
            errors++;
            $display("[TB] FAIL after_reset_idle got %h want %h", allOutputs(), 36'h0);
        end
    endtask

    task automatic test_capture_12h();
        int capIn[4] = '{0, 12, 13, 23};
        int expH[4]  = '{12, 12, 1, 11};
        int expPm[4] = '{0, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            doCapture(1'b1, 5'(capIn[i]), 6'd30);
            checks++;
            if ({tsc.o_editing, tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes} !==
                {1'b1, 5'(expH[i]), 1'(expPm[i]), 6'd30}) begin
                errors++;
                $display("[TB] FAIL capture_12h_%0d got ed=%0d h=%0d pm=%0d m=%0d want ed=1 h=%0d pm=%0d m=30",
                         capIn[i], tsc.o_editing, tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes,
                         expH[i], expPm[i]);
            end
            doCancel();
            checks++;
            if ({tsc.o_editing, tsc.o_set_valid, tsc.o_disp_hours} !== {1'b0, 1'b0, 5'(expH[i])}) begin
                errors++;
                $display("[TB] FAIL cancel_hold_%0d got ed=%0d v=%0d h=%0d want ed=0 v=0 h=%0d",
                         capIn[i], tsc.o_editing, tsc.o_set_valid, tsc.o_disp_hours, expH[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        doCapture(1'b1, 5'd30, 6'd63);
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes} !== {5'd12, 1'b0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL range_12h got h=%0d pm=%0d m=%0d want h=12 pm=0 m=0",
                     tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes);
        end
        doCancel();
        doCapture(1'b0, 5'd24, 6'd60);
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes} !== {5'd0, 1'b0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL range_24h got h=%0d pm=%0d m=%0d want h=0 pm=0 m=0",
                     tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes);
        end
        doCancel();
    endtask

    task automatic test_inc_12h();
        tsc.i_set_ready = 1'b1;
        // First run: 11 AM -> 12 PM, commits as noon.
        doCapture(1'b1, 5'd11, 6'd5);
        doIncHours();
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm} !== {5'd12, 1'b1}) begin
            errors++;
            $display("[TB] FAIL inc_11_to_12 got h=%0d pm=%0d want h=12 pm=1", tsc.o_disp_hours, tsc.o_disp_pm);
        end
        doCommit();
        checks++;
        if ({tsc.o_set_valid, tsc.o_editing, tsc.o_hours, tsc.o_minutes} !== {1'b1, 1'b0, 5'd12, 6'd5}) begin
            errors++;
            $display("[TB] FAIL commit_noon got v=%0d ed=%0d h=%0d m=%0d want v=1 ed=0 h=12 m=5",
                     tsc.o_set_valid, tsc.o_editing, tsc.o_hours, tsc.o_minutes);
        end
        tick();
        checks++;
        if (tsc.o_set_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL commit_noon_drop got v=%0d want v=0", tsc.o_set_valid);
        end
        // Second run: 11 AM -> 12 PM -> 1 PM, commits as 13.
        doCapture(1'b1, 5'd11, 6'd5);
        doIncHours();
        doIncHours();
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm} !== {5'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL inc_12_to_1 got h=%0d pm=%0d want h=1 pm=1", tsc.o_disp_hours, tsc.o_disp_pm);
        end
        doCommit();
        checks++;
        if ({tsc.o_set_valid, tsc.o_hours} !== {1'b1, 5'd13}) begin
            errors++;
            $display("[TB] FAIL commit_13 got v=%0d h=%0d want v=1 h=13", tsc.o_set_valid, tsc.o_hours);
        end
        tick();
        // 12 AM -> 1 AM keeps AM and commits as 1; 11 PM -> 12 AM commits as 0.
        doCapture(1'b1, 5'd0, 6'd0);
        doIncHours();
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm} !== {5'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL inc_12am_to_1 got h=%0d pm=%0d want h=1 pm=0", tsc.o_disp_hours, tsc.o_disp_pm);
        end
        doCommit();
        checks++;
        if (tsc.o_hours !== 5'd1) begin
            errors++;
            $display("[TB] FAIL commit_1am got h=%0d want h=1", tsc.o_hours);
        end
        tick();
        doCapture(1'b1, 5'd23, 6'd0);
        doIncHours();
        doCommit();
        checks++;
        if ({tsc.o_set_valid, tsc.o_hours} !== {1'b1, 5'd0}) begin
            errors++;
            $display("[TB] FAIL commit_midnight got v=%0d h=%0d want v=1 h=0", tsc.o_set_valid, tsc.o_hours);
        end
        tick();
    endtask

    task automatic test_wrap_24h();
        tsc.i_set_ready = 1'b1;
        doCapture(1'b0, 5'd23, 6'd59);
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes} !== {5'd23, 1'b0, 6'd59}) begin
            errors++;
            $display("[TB] FAIL capture_2359 got h=%0d pm=%0d m=%0d want h=23 pm=0 m=59",
                     tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes);
        end
        tsc.i_inc_hours   = 1'b1;
        tsc.i_inc_minutes = 1'b1;
        tick();
        tsc.i_inc_hours   = 1'b0;
        tsc.i_inc_minutes = 1'b0;
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_minutes} !== {5'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_both got h=%0d m=%0d want h=0 m=0", tsc.o_disp_hours, tsc.o_disp_minutes);
        end
        doCommit();
        checks++;
        if ({tsc.o_set_valid, tsc.o_hours, tsc.o_minutes, tsc.o_seconds} !== {1'b1, 5'd0, 6'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL commit_0000 got v=%0d h=%0d m=%0d s=%0d want v=1 h=0 m=0 s=0",
                     tsc.o_set_valid, tsc.o_hours, tsc.o_minutes, tsc.o_seconds);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        tsc.i_set_ready = 1'b0;
        doCapture(1'b0, 5'd14, 6'd7);
        tsc.i_inc_minutes = 1'b1;
        tick();
        tick();
        tick();
        tsc.i_inc_minutes = 1'b0;
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_minutes} !== {5'd14, 6'd10}) begin
            errors++;
            $display("[TB] FAIL b2b_minutes got h=%0d m=%0d want h=14 m=10", tsc.o_disp_hours, tsc.o_disp_minutes);
        end
        doCommit();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) tsc.i_set_ready = 1'b1;
            checks++;
            if ({tsc.o_set_valid, tsc.o_editing, tsc.o_hours, tsc.o_minutes, tsc.o_seconds} !==
                {1'b1, 1'b0, 5'd14, 6'd10, 6'd0}) begin
                errors++;
                $display("[TB] FAIL hold_cycle_%0d got v=%0d ed=%0d h=%0d m=%0d want v=1 ed=0 h=14 m=10",
                         c, tsc.o_set_valid, tsc.o_editing, tsc.o_hours, tsc.o_minutes);
            end
            // Strobes during the offer must be ignored.
            tsc.i_start     = (c == 2);
            tsc.i_inc_hours = (c == 3);
            tick();
            tsc.i_start     = 1'b0;
            tsc.i_inc_hours = 1'b0;
        end
        checks++;
        if ({tsc.o_set_valid, tsc.o_editing, tsc.o_disp_hours, tsc.o_disp_minutes} !==
            {1'b0, 1'b0, 5'd14, 6'd10}) begin
            errors++;
            $display("[TB] FAIL accept_drop got v=%0d ed=%0d h=%0d m=%0d want v=0 ed=0 h=14 m=10",
                     tsc.o_set_valid, tsc.o_editing, tsc.o_disp_hours, tsc.o_disp_minutes);
        end
    endtask

    task automatic test_priority_and_mode();
        tsc.i_set_ready = 1'b1;
        doCapture(1'b1, 5'd21, 6'd15);
        tsc.i_12h_mode = 1'b0;
        tick();
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes} !== {5'd9, 1'b1, 6'd15}) begin
            errors++;
            $display("[TB] FAIL mode_toggle got h=%0d pm=%0d m=%0d want h=9 pm=1 m=15",
                     tsc.o_disp_hours, tsc.o_disp_pm, tsc.o_disp_minutes);
        end
        doIncHours();
        checks++;
        if ({tsc.o_disp_hours, tsc.o_disp_pm} !== {5'd10, 1'b1}) begin
            errors++;
            $display("[TB] FAIL frozen_mode_inc got h=%0d pm=%0d want h=10 pm=1", tsc.o_disp_hours, tsc.o_disp_pm);
        end
        tsc.i_cancel    = 1'b1;
        tsc.i_commit    = 1'b1;
        tsc.i_inc_hours = 1'b1;
        tick();
        tsc.i_cancel    = 1'b0;
        tsc.i_commit    = 1'b0;
        tsc.i_inc_hours = 1'b0;
        checks++;
        if ({tsc.o_editing, tsc.o_set_valid, tsc.o_disp_hours} !== {1'b0, 1'b0, 5'd10}) begin
            errors++;
            $display("[TB] FAIL cancel_beats_commit got ed=%0d v=%0d h=%0d want ed=0 v=0 h=10",
                     tsc.o_editing, tsc.o_set_valid, tsc.o_disp_hours);
        end
        tick();
        checks++;
        if (tsc.o_set_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_no_offer got v=%0d want v=0", tsc.o_set_valid);
        end
        doCapture(1'b0, 5'd8, 6'd20);
        tsc.i_commit      = 1'b1;
        tsc.i_inc_minutes = 1'b1;
        tick();
        tsc.i_commit      = 1'b0;
        tsc.i_inc_minutes = 1'b0;
        checks++;
        if ({tsc.o_set_valid, tsc.o_hours, tsc.o_minutes} !== {1'b1, 5'd8, 6'd20}) begin
            errors++;
            $display("[TB] FAIL commit_beats_inc got v=%0d h=%0d m=%0d want v=1 h=8 m=20",
                     tsc.o_set_valid, tsc.o_hours, tsc.o_minutes);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        tsc.i_set_ready = 1'b0;
        doCapture(1'b1, 5'd15, 6'd45);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (allOutputs() !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_edit got %h want %h", allOutputs(), 36'h0);
        end
        #2 reset = 1'b0;
        tick();
        doCapture(1'b0, 5'd6, 6'd30);
        doCommit();
        checks++;
        if ({tsc.o_set_valid, tsc.o_hours} !== {1'b1, 5'd6}) begin
            errors++;
            $display("[TB] FAIL pre_reset_offer got v=%0d h=%0d want v=1 h=6", tsc.o_set_valid, tsc.o_hours);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (allOutputs() !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_commit got %h want %h", allOutputs(), 36'h0);
        end
        #2 reset = 1'b0;
        tick();
        // Back in IDLE: increments must not touch the staged value.
        doIncHours();
        checks++;
        if ({tsc.o_editing, tsc.o_set_valid, tsc.o_disp_hours} !== {1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got ed=%0d v=%0d h=%0d want ed=0 v=0 h=0",
                     tsc.o_editing, tsc.o_set_valid, tsc.o_disp_hours);
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        tsc.i_12h_mode    = 1'b0;
        tsc.i_cur_hours   = '0;
        tsc.i_cur_minutes = '0;
        tsc.i_start       = 1'b0;
        tsc.i_inc_hours   = 1'b0;
        tsc.i_inc_minutes = 1'b0;
        tsc.i_commit      = 1'b0;
        tsc.i_cancel      = 1'b0;
        tsc.i_set_ready   = 1'b0;

        test_reset();
        test_capture_12h();
        test_out_of_range();
        test_inc_12h();
        test_wrap_24h();
        test_back_to_back();
        test_priority_and_mode();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
